pwm_multichannel_core: RTL

Parametrised successor to the fixed three-channel PWM datapath, sized by channel count and counter width. Each channel has a period counter (up, down or up-down), two compare outputs and a sync/phase chain from channel k-1 to channel k. Compare, period and phase values are double-buffered: writes land in shadow registers and are copied to the active set at the counter zero event. Channels share a latched trip input that forces all outputs low. The block sits between the register-write decode and the deadband/pad stage.

---
 rtl/pwm_multichannel_core_if.sv | 22 ++
 rtl/pwm_multichannel_core.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multichannel_core_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multichannel_core_if
// Description : Register-write bus from the register decode block into the
//               multichannel PWM core (strobe, channel, select, data).
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_multichannel_core_if #(
  parameter int CH_IDX_W  = 2,
  parameter int CNT_WIDTH = 16
);
  logic                 i_wr_en;
  logic [CH_IDX_W-1:0]  i_wr_ch;
  logic [2:0]           i_wr_sel;
  logic [CNT_WIDTH-1:0] i_wr_data;

  // Register decode side drives the bus
  modport master (output i_wr_en, i_wr_ch, i_wr_sel, i_wr_data);
  // PWM core side consumes the bus
  modport slave  (input  i_wr_en, i_wr_ch, i_wr_sel, i_wr_data);
endinterface
`default_nettype wire

// File: rtl/pwm_multichannel_core.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multichannel_core
// Description : CH_COUNT-channel PWM core. Each channel has an up/down/
//               up-down/hold period counter, two compare outputs, a sync/
//               phase chain from channel k-1 and a shared latched trip.
//               Define PWM_SHADOW_EN to double-buffer PERIOD/CMPA/CMPB/PHASE
//               (load at counter zero event); otherwise writes hit the
//               active registers directly.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multichannel_core #(
  parameter int CH_COUNT  = 3,
  parameter int CNT_WIDTH = 16
) (
  input  wire logic                          clk,
  input  wire logic                          rst_n,
  pwm_multichannel_core_if.slave             wr_bus,
  input  wire logic                          i_sync_in,
  input  wire logic                          i_trip,
  output logic [CH_COUNT-1:0]                o_pwm_a,
  output logic [CH_COUNT-1:0]                o_pwm_b,
  output logic [CH_COUNT-1:0]                o_sync,
  output logic [CH_COUNT-1:0]                o_trip,
  output logic [CH_COUNT*CNT_WIDTH-1:0]      o_counter
);

  localparam int CH_IDX_W = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;

  localparam logic [2:0] SEL_CTRL     = 3'd0;
  localparam logic [2:0] SEL_PERIOD   = 3'd1;
  localparam logic [2:0] SEL_CMPA     = 3'd2;
  localparam logic [2:0] SEL_CMPB     = 3'd3;
  localparam logic [2:0] SEL_PHASE    = 3'd4;
  localparam logic [2:0] SEL_TRIP_CLR = 3'd5;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_UPDN = 2'b10;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // CTRL field view of the write data; narrow counters zero-extend it
  logic [4:0] ctrl_wr;
  if (CNT_WIDTH >= 5) begin : g_ctrl_wide
    assign ctrl_wr = wr_bus.i_wr_data[4:0];
  end else begin : g_ctrl_narrow
    assign ctrl_wr = 5'(wr_bus.i_wr_data);
  end

  // Two-flop synchroniser for the asynchronous trip request
  logic trip_meta_q, trip_meta_d, trip_sync_q, trip_sync_d;

  // Trip synchroniser next-state
  always_comb begin
    trip_meta_d = i_trip;
    trip_sync_d = trip_meta_q;
  end

  // Trip synchroniser registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trip_meta_q <= 1'b0;
      trip_sync_q <= 1'b0;
    end else begin
      trip_meta_q <= trip_meta_d;
      trip_sync_q <= trip_sync_d;
    end
  end

  for (genvar k = 0; k < CH_COUNT; k++) begin : g_ch
    logic [4:0]           ctrl_q, ctrl_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] per_q, per_d, cmpa_q, cmpa_d;
    logic [CNT_WIDTH-1:0] cmpb_q, cmpb_d, phase_q, phase_d;
    logic                 dir_q, dir_d;
    logic                 pwm_a_q, pwm_a_d, pwm_b_q, pwm_b_d;
    logic                 sync_q, sync_d, trip_q, trip_d;
    logic                 wr_hit, en, zero_ev, sync_src, go_up;
    logic [1:0]           mode;
    logic [CNT_WIDTH-1:0] phase_clamp;
`ifdef PWM_SHADOW_EN
    logic [CNT_WIDTH-1:0] sh_per_q, sh_per_d, sh_cmpa_q, sh_cmpa_d;
    logic [CNT_WIDTH-1:0] sh_cmpb_q, sh_cmpb_d, sh_phase_q, sh_phase_d;
`endif

    if (k == 0) begin : g_src_ext
      assign sync_src = i_sync_in;
    end else begin : g_src_chain
      assign sync_src = o_sync[k-1];
    end

    // Out-of-range channel numbers never match any k, so they are dropped
    assign wr_hit      = wr_bus.i_wr_en && (wr_bus.i_wr_ch == CH_IDX_W'(k));
    assign en          = ctrl_q[0];
    assign mode        = ctrl_q[2:1];
    assign zero_ev     = en && (cnt_q == '0);
    assign phase_clamp = (phase_q < per_q) ? phase_q : per_q;

    // Counter and direction next-state; phase load beats counting and hold
    always_comb begin
      cnt_d = cnt_q;
      dir_d = dir_q;
      go_up = 1'b0;
      if (!en) begin
        cnt_d = '0;
        dir_d = DIR_UP;
      end else if (ctrl_q[3] && sync_src) begin
        cnt_d = phase_clamp;
        if (mode == MODE_UPDN) dir_d = ctrl_q[4];
      end else begin
        case (mode)
          MODE_UP:   cnt_d = (cnt_q >= per_q) ? '0 : cnt_q + CNT_ONE;
          MODE_DOWN: cnt_d = (cnt_q == '0) ? per_q : cnt_q - CNT_ONE;
          MODE_UPDN: begin
            if (per_q == '0) begin
              cnt_d = '0;
              dir_d = DIR_UP;
            end else begin
              // Bottom always turns upward; top (or above) always turns down
              go_up = ((dir_q == DIR_UP) && (cnt_q < per_q)) || (cnt_q == '0);
              cnt_d = go_up ? cnt_q + CNT_ONE : cnt_q - CNT_ONE;
              dir_d = ((go_up && (cnt_d < per_q)) || (cnt_d == '0)) ? DIR_UP : DIR_DOWN;
            end
          end
          default: cnt_d = cnt_q;
        endcase
      end
    end

    // Register file next-state: CTRL direct, others shadowed or direct
    always_comb begin
      ctrl_d = (wr_hit && (wr_bus.i_wr_sel == SEL_CTRL)) ? ctrl_wr : ctrl_q;
`ifdef PWM_SHADOW_EN
      sh_per_d   = (wr_hit && (wr_bus.i_wr_sel == SEL_PERIOD)) ? wr_bus.i_wr_data : sh_per_q;
      sh_cmpa_d  = (wr_hit && (wr_bus.i_wr_sel == SEL_CMPA))   ? wr_bus.i_wr_data : sh_cmpa_q;
      sh_cmpb_d  = (wr_hit && (wr_bus.i_wr_sel == SEL_CMPB))   ? wr_bus.i_wr_data : sh_cmpb_q;
      sh_phase_d = (wr_hit && (wr_bus.i_wr_sel == SEL_PHASE))  ? wr_bus.i_wr_data : sh_phase_q;
      // Load uses the pre-edge shadow, so a same-edge write waits one period
      if (!en || zero_ev) begin
        per_d   = sh_per_q;
        cmpa_d  = sh_cmpa_q;
        cmpb_d  = sh_cmpb_q;
        phase_d = sh_phase_q;
      end else begin
        per_d   = per_q;
        cmpa_d  = cmpa_q;
        cmpb_d  = cmpb_q;
        phase_d = phase_q;
      end
`else
      per_d   = (wr_hit && (wr_bus.i_wr_sel == SEL_PERIOD)) ? wr_bus.i_wr_data : per_q;
      cmpa_d  = (wr_hit && (wr_bus.i_wr_sel == SEL_CMPA))   ? wr_bus.i_wr_data : cmpa_q;
      cmpb_d  = (wr_hit && (wr_bus.i_wr_sel == SEL_CMPB))   ? wr_bus.i_wr_data : cmpb_q;
      phase_d = (wr_hit && (wr_bus.i_wr_sel == SEL_PHASE))  ? wr_bus.i_wr_data : phase_q;
`endif
    end

    // Trip flag (set beats clear) and registered compare/sync outputs
    always_comb begin
      if (trip_sync_q)
        trip_d = 1'b1;
      else if (wr_hit && (wr_bus.i_wr_sel == SEL_TRIP_CLR))
        trip_d = 1'b0;
      else
        trip_d = trip_q;
      // Gate with the incoming flag so outputs drop on the edge it sets
      pwm_a_d = en && !trip_d && (cnt_q < cmpa_q);
      pwm_b_d = en && !trip_d && (cnt_q < cmpb_q);
      sync_d  = zero_ev;
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctrl_q     <= '0;
        cnt_q      <= '0;
        dir_q      <= DIR_UP;
        per_q      <= '0;
        cmpa_q     <= '0;
        cmpb_q     <= '0;
        phase_q    <= '0;
        pwm_a_q    <= 1'b0;
        pwm_b_q    <= 1'b0;
        sync_q     <= 1'b0;
        trip_q     <= 1'b0;
`ifdef PWM_SHADOW_EN
        sh_per_q   <= '0;
        sh_cmpa_q  <= '0;
        sh_cmpb_q  <= '0;
        sh_phase_q <= '0;
`endif
      end else begin
        ctrl_q     <= ctrl_d;
        cnt_q      <= cnt_d;
        dir_q      <= dir_d;
        per_q      <= per_d;
        cmpa_q     <= cmpa_d;
        cmpb_q     <= cmpb_d;
        phase_q    <= phase_d;
        pwm_a_q    <= pwm_a_d;
        pwm_b_q    <= pwm_b_d;
        sync_q     <= sync_d;
        trip_q     <= trip_d;
`ifdef PWM_SHADOW_EN
        sh_per_q   <= sh_per_d;
        sh_cmpa_q  <= sh_cmpa_d;
        sh_cmpb_q  <= sh_cmpb_d;
        sh_phase_q <= sh_phase_d;
`endif
      end
    end

    assign o_pwm_a[k]                          = pwm_a_q;
    assign o_pwm_b[k]                          = pwm_b_q;
    assign o_sync[k]                           = sync_q;
    assign o_trip[k]                           = trip_q;
    assign o_counter[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

endmodule
`default_nettype wire
